// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte interface among NUM_REQ packet sources.
// Define UART_ARB_HDR_EN to prefix each packet with the channel-ID byte HDR_BASE | grant_id.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter logic [7:0]  HDR_BASE = 8'hA0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 grant_active,
    output logic [2:0]           grant_id
);

`ifdef UART_ARB_HDR_EN
    localparam bit HdrEn = 1'b1;
`else
    localparam bit HdrEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StWaitHdr,
        StData,
        StWaitData
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  grant_id_q, grant_id_d;
    logic        grant_active_q, grant_active_d;
    logic [2:0]  rr_last_q, rr_last_d;
    logic        last_q, last_d;

    logic               pick_found;
    logic [2:0]         pick_idx;
    logic [3:0]         cand_sum;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic [7:0]         gnt_data;
    logic               gnt_last;
    logic               gnt_valid;

    // Search rr_last+1, rr_last+2, ... modulo NUM_REQ; first valid requester wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_sum   = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand_sum = 4'(rr_last_q) + 4'(k);
            if (cand_sum >= 4'(NUM_REQ)) begin
                cand_sum = cand_sum - 4'(NUM_REQ);
            end
            for (int j = 0; j < int'(NUM_REQ); j++) begin
                if (!pick_found && req_valid[j] && (cand_sum == 4'(j))) begin
                    pick_found = 1'b1;
                    pick_idx   = cand_sum[2:0];
                end
            end
        end
    end

    always_comb begin
        gnt_onehot = '0;
        gnt_data   = '0;
        gnt_last   = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_id_q == 3'(i)) begin
                gnt_onehot[i] = 1'b1;
                gnt_data      = req_data[8*i +: 8];
                gnt_last      = req_last[i];
            end
        end
    end

    assign gnt_valid = |(req_valid & gnt_onehot);

    always_comb begin
        state_d        = state_q;
        grant_id_d     = grant_id_q;
        grant_active_d = grant_active_q;
        rr_last_d      = rr_last_q;
        last_d         = last_q;
        tx_start       = 1'b0;
        tx_data        = 8'h00;
        req_ready      = '0;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_id_d     = pick_idx;
                    grant_active_d = 1'b1;
                    state_d        = HdrEn ? StHdr : StData;
                end
            end
            StHdr: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    tx_data  = HDR_BASE | {5'b00000, grant_id_q};
                    state_d  = StWaitHdr;
                end
            end
            StWaitHdr: begin
                if (!tx_busy) begin
                    state_d = StData;
                end
            end
            StData: begin
                // Handshake and frame launch share the cycle, so the byte is never buffered here.
                if (gnt_valid && !tx_busy) begin
                    req_ready = gnt_onehot;
                    tx_start  = 1'b1;
                    tx_data   = gnt_data;
                    last_d    = gnt_last;
                    state_d   = StWaitData;
                end
            end
            StWaitData: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        rr_last_d      = grant_id_q;
                        grant_active_d = 1'b0;
                        state_d        = StIdle;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            grant_id_q     <= '0;
            grant_active_q <= 1'b0;
            rr_last_q      <= 3'(NUM_REQ - 1);
            last_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_id_q     <= grant_id_d;
            grant_active_q <= grant_active_d;
            rr_last_q      <= rr_last_d;
            last_q         <= last_d;
        end
    end

    assign grant_active = grant_active_q;
    assign grant_id     = grant_id_q;

endmodule
